// File: rtl/xy_scan_ctrl_if.sv
// Scan sequencer bus: flag-stage feedback, pixel-address handshake, status.
// Pure wiring, no latency of its own.
// addr_valid/addr_ack handshake; the master holds addr stable while unacknowledged.
interface xy_scan_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic              x_flag;
  logic              y_flag;
  logic              addr_ack;
  logic [15:0]       x_reg;
  logic [15:0]       y_reg;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              row_end;
  logic              busy;
  logic              done;

  modport master (
    input  start, x_flag, y_flag, addr_ack,
    output x_reg, y_reg, addr, addr_valid, row_end, busy, done
  );

  modport slave (
    output start, x_flag, y_flag, addr_ack,
    input  x_reg, y_reg, addr, addr_valid, row_end, busy, done
  );
endinterface

// File: rtl/xy_scan_ctrl.sv
// Downsampling X/Y scan sequencer emitting one pixel address per sampled grid point.
// start -> first addr_valid after 2 cycles; 2 cycles per sample, +1 per row.
// EMIT waits indefinitely for addr_ack with addr, x_reg and y_reg frozen.
module xy_scan_ctrl #(
  parameter int STEP   = 2,
  parameter int IMG_W  = 256,
  parameter int ADDR_W = 16
) (
  input logic            clock,
  input logic            reset,
  xy_scan_ctrl_if.master bus
);

  // Product width wide enough for a 16-bit row index times the image width.
  localparam int PW = (ADDR_W > 32) ? ADDR_W : 32;

  typedef enum logic [2:0] {
    IDLE,
    CHK_ROW,
    EMIT,
    CHK_COL,
    DONE
  } state_t;

  state_t            state;
  logic [15:0]       x_reg;
  logic [15:0]       y_reg;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              row_end;
  logic              busy;
  logic              done;
  logic [15:0]       x_inc;
  logic [15:0]       y_inc;

  // Positions clamp at 0xFFFF so a full-range limit still ends the row/frame.
  function automatic logic [15:0] sat_step(input logic [15:0] v);
    logic [16:0] s;
    s = {1'b0, v} + 17'(STEP);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Row-major linear address, truncated to the address width.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [15:0] x, input logic [15:0] y);
    logic [PW-1:0] p;
    p = (PW'(y) * PW'(IMG_W)) + PW'(x);
    return p[ADDR_W-1:0];
  endfunction

  // Next candidate positions, shared by the column and row advance paths.
  always_comb begin
    x_inc = sat_step(x_reg);
    y_inc = sat_step(y_reg);
  end

  // Scan FSM; addr is loaded alongside the positions so it always matches them.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      x_reg      <= '0;
      y_reg      <= '0;
      addr       <= '0;
      addr_valid <= 1'b0;
      row_end    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      row_end <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            x_reg <= '0;
            y_reg <= '0;
            addr  <= '0;
            busy  <= 1'b1;
            state <= CHK_ROW;
          end
        end
        CHK_ROW: begin
          if (bus.y_flag && bus.x_flag) begin
            addr_valid <= 1'b1;
            state      <= EMIT;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        EMIT: begin
          if (bus.addr_ack) begin
            addr_valid <= 1'b0;
            x_reg      <= x_inc;
            addr       <= lin_addr(x_inc, y_reg);
            state      <= CHK_COL;
          end
        end
        CHK_COL: begin
          if (bus.x_flag) begin
            addr_valid <= 1'b1;
            state      <= EMIT;
          end else begin
            x_reg   <= '0;
            y_reg   <= y_inc;
            addr    <= lin_addr(16'd0, y_inc);
            row_end <= 1'b1;
            state   <= CHK_ROW;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered values presented on the bus.
  always_comb begin
    bus.x_reg      = x_reg;
    bus.y_reg      = y_reg;
    bus.addr       = addr;
    bus.addr_valid = addr_valid;
    bus.row_end    = row_end;
    bus.busy       = busy;
    bus.done       = done;
  end

endmodule

// File: tb/tb_xy_scan_ctrl.sv
// Bench for xy_scan_ctrl: directed and randomized scans against a loop-based frame model.
// Outputs sampled and inputs driven on the falling clock edge.
// addr_ack driven always-high, randomly, or held low to exercise the EMIT hold.
module tb_xy_scan_ctrl;

  localparam int STEP  = 2;
  localparam int IMG_W = 11;
  localparam int AW    = 16;
  localparam int BOUND = 70000;

  localparam int M_ACK1    = 0;
  localparam int M_RAND    = 1;
  localparam int M_HOLD    = 2;
  localparam int M_RESTART = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] xlim = '0;
  logic [15:0] ylim = '0;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  int got[$];
  int exp_q[$];
  int exp_rows;
  int n_valid, n_row, n_done, done_cyc, first_vld, sat_x, wrapped;

  xy_scan_ctrl_if #(.ADDR_W(AW)) bus ();

  // Comparator flag stage driven by the bench-controlled limits.
  assign bus.x_flag = (bus.x_reg < xlim);
  assign bus.y_flag = (bus.y_reg < ylim);

  xy_scan_ctrl #(.STEP(STEP), .IMG_W(IMG_W), .ADDR_W(AW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat_i(input int v);
    return (v + STEP > 65535) ? 65535 : v + STEP;
  endfunction

  // Frame model: the downsampled grid is every (x,y) reached by stepping from 0 while below the limits.
  task automatic build_model(input int xl, input int yl);
    exp_q.delete();
    exp_rows = 0;
    if (xl > 0) begin
      for (int y = 0; y < yl; y = sat_i(y)) begin
        exp_rows++;
        for (int x = 0; x < xl; x = sat_i(x))
          exp_q.push_back((y * IMG_W + x) % 65536);
      end
    end
  endtask

  task automatic run_scan(input int xl, input int yl, input int mode);
    int          held;
    int          fin;
    logic        ack;
    logic [15:0] prev_x;
    held = 0; fin = 0; prev_x = '0;
    xlim = 16'(xl); ylim = 16'(yl);
    got.delete();
    n_valid = 0; n_row = 0; n_done = 0; done_cyc = -1; first_vld = -1; sat_x = -1; wrapped = 0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.addr_ack = 1'b0;
    for (int c = 1; c < BOUND && fin == 0; c++) begin
      @(negedge clk);
      bus.start = (mode == M_RESTART && c == 5);
      if (bus.addr_valid) begin
        n_valid++;
        if (first_vld < 0) first_vld = c;
      end
      if (bus.row_end && n_row == 0) sat_x = int'(prev_x);
      if (bus.row_end) n_row++;
      if (n_row == 0 && bus.x_reg < prev_x) wrapped = 1;
      prev_x = bus.x_reg;
      if (bus.done) begin
        n_done++;
        done_cyc = c;
      end else if (n_done > 0 && !bus.busy) begin
        fin = 1;
      end
      case (mode)
        M_RAND: ack = 1'($urandom_range(0, 1));
        M_HOLD: begin
          ack = 1'b1;
          if (bus.addr_valid && got.size() == 1 && held < 4) begin
            check("hold_addr", 32'(bus.addr), 32'd2);
            ack = 1'b0;
            held++;
          end
        end
        default: ack = 1'b1;
      endcase
      if (bus.addr_valid && ack) begin
        got.push_back(int'(bus.addr));
        check("addr_vs_pos", 32'(bus.addr),
              32'((int'(bus.y_reg) * IMG_W + int'(bus.x_reg)) % 65536));
      end
      bus.addr_ack = ack;
    end
    check("scan_finished", 32'(fin), 32'd1);
    bus.addr_ack = 1'b0;
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check({tag, "_addr"}, 32'(got[i]), 32'(exp_q[i]));
    check({tag, "_rows"}, 32'(n_row), 32'(exp_rows));
    check({tag, "_done"}, 32'(n_done), 32'd1);
    check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, 32'(bus.x_reg), 32'd0);
    check({tag, "_y"}, 32'(bus.y_reg), 32'd0);
    check({tag, "_addr"}, 32'(bus.addr), 32'd0);
    check({tag, "_vld"}, 32'(bus.addr_valid), 32'd0);
    check({tag, "_row_end"}, 32'(bus.row_end), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int xl, yl, hit;
    bus.start    = 1'b0;
    bus.addr_ack = 1'b0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Basic 5x5 frame, ack always high.
    build_model(5, 5);
    check("model_len", 32'(exp_q.size()), 32'd9);
    run_scan(5, 5, M_ACK1);
    compare_frame("basic");
    check("basic_valid_cycles", 32'(n_valid), 32'd9);
    check("basic_first_vld", 32'(first_vld), 32'd2);
    check("basic_done_cyc", 32'(done_cyc), 32'(2 + 2 * exp_q.size() + exp_rows));

    // Consumer stalls the second address for 4 cycles.
    run_scan(5, 5, M_HOLD);
    compare_frame("hold");
    check("hold_valid_cycles", 32'(n_valid), 32'd13);

    // Zero X limit, then zero Y limit: no samples, done 2 cycles after start.
    build_model(0, 5);
    run_scan(0, 5, M_ACK1);
    compare_frame("xzero");
    check("xzero_valid", 32'(n_valid), 32'd0);
    check("xzero_done_cyc", 32'(done_cyc), 32'd2);
    build_model(5, 0);
    run_scan(5, 0, M_ACK1);
    compare_frame("yzero");
    check("yzero_valid", 32'(n_valid), 32'd0);
    check("yzero_done_cyc", 32'(done_cyc), 32'd2);

    // Start pulsed again mid-scan must not disturb the frame.
    build_model(5, 5);
    run_scan(5, 5, M_RESTART);
    compare_frame("restart");
    check("restart_done_cyc", 32'(done_cyc), 32'(2 + 2 * exp_q.size() + exp_rows));

    // Reset while addr=24 is being offered.
    xlim = 16'd5; ylim = 16'd5; hit = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 0; c < 100 && hit == 0; c++) begin
      @(negedge clk);
      bus.start    = 1'b0;
      bus.addr_ack = 1'b1;
      if (bus.addr_valid && bus.addr == 16'd24) begin
        hit          = 1;
        rst          = 1'b1;
        bus.addr_ack = 1'b0;
      end
    end
    check("reach_addr24", 32'(hit), 32'd1);
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midreset_idle");
    run_scan(5, 5, M_ACK1);
    compare_frame("after_reset");

    // Randomized limits with random acknowledge timing.
    for (int r = 0; r < 6; r++) begin
      xl = $urandom_range(0, 12);
      yl = $urandom_range(0, 9);
      build_model(xl, yl);
      run_scan(xl, yl, M_RAND);
      compare_frame("rand");
    end

    // Full-range X limit: x saturates at 0xFFFF and the row ends without wrapping.
    build_model(65535, 1);
    run_scan(65535, 1, M_ACK1);
    compare_frame("sat");
    check("sat_x_before_row_end", 32'(sat_x), 32'd65535);
    check("sat_no_wrap", 32'(wrapped), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/xy_scan_ctrl.md
Name: xy_scan_ctrl

Overview:
- Downsampling scan sequencer that owns the X/Y position registers.
- Drives x_reg/y_reg into the comparator flag stage and consumes its x_flag/y_flag to decide column and row advance.
- Emits one source-pixel memory address per sampled position over a valid/ack handshake to the pixel fetch path.
- Steps by STEP in both axes to produce the downsampled grid; signals end of each row and end of frame.

Parameters:
- STEP, 2, sampling stride applied to both X and Y.
- IMG_W, 256, source image width in pixels; used for address linearisation.
- ADDR_W, 16, width of the emitted pixel address.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clock.
- start  in  1  begin a frame scan; honoured only in IDLE.
- x_flag  in  1  from flag stage: high when x_reg < X limit.
- y_flag  in  1  from flag stage: high when y_reg < Y limit.
- addr_ack  in  1  consumer accepted the current address.
- x_reg  out  16  current column position; feeds flag stage.
- y_reg  out  16  current row position; feeds flag stage.
- addr  out  ADDR_W  registered (y_reg*IMG_W + x_reg) mod 2^ADDR_W.
- addr_valid  out  1  addr holds a sample position awaiting ack.
- row_end  out  1  one-cycle pulse when a row completes.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the frame completes.

Behaviour:
- States: IDLE, CHK_ROW, EMIT, CHK_COL, DONE. Flags are combinational on x_reg/y_reg and are evaluated in CHK_ROW/CHK_COL one cycle after the position update.
- Reset, including mid-scan: state=IDLE; x_reg=0, y_reg=0, addr=0; addr_valid, row_end, busy, done = 0. Any pending address is dropped without ack.
- IDLE:
  - start=1 -> x_reg=0, y_reg=0, go to CHK_ROW.
  - start=0 -> hold.
- CHK_ROW:
  - y_flag && x_flag -> EMIT.
  - Otherwise -> DONE. This covers a zero limit or the frame being exhausted.
- EMIT:
  - addr_valid=1; addr and x/y held stable until ack.
  - addr_ack=1 -> x_reg += STEP, go to CHK_COL.
  - addr_ack=0 -> stay in EMIT.
  - addr_ack outside EMIT is ignored.
- CHK_COL:
  - x_flag=1 -> EMIT.
  - x_flag=0 -> x_reg=0, y_reg += STEP, row_end=1 for this cycle, go to CHK_ROW.
- DONE: done=1 for exactly one cycle -> IDLE. busy drops on the following cycle.
- start while busy is ignored; no restart and no queueing.
- Throughput: with addr_ack tied high, each sample takes 2 cycles (EMIT, CHK_COL). Each row adds 1 cycle (CHK_ROW).
- Latency: start at cycle 0 -> first addr_valid at cycle 2.
- Arithmetic:
  - x_reg and y_reg saturate at 0xFFFF on +STEP and never wrap, so a limit of 0xFFFF terminates.
  - addr is updated in the same cycle as x_reg/y_reg, computed from their next values, so it matches the positions whenever addr_valid=1.
  - Multiply result is truncated to ADDR_W.
- Flag limits are written into the flag stage by other logic. Changing them mid-scan takes effect at the next CHK state and is legal.

Test Plan:
- STEP=2, IMG_W=11, limits X=5/Y=5, addr_ack tied 1, pulse start -> addr sequence 0,2,4,22,24,26,44,46,48. Exactly 9 addr_valid cycles, 3 row_end pulses, then one done pulse and busy=0.
- Same setup with addr_ack held low 4 cycles on the second address -> addr=2 and addr_valid stay stable for 4 cycles. Sequence unchanged; no skipped or duplicated address.
- X limit=0 -> start gives no addr_valid; done pulses 2 cycles after start.
- Y limit=0 -> same response as X limit=0.
- Assert reset while in EMIT at addr=24 -> next cycle all outputs 0 and state IDLE. A fresh start restarts at addr=0.
- Pulse start again at cycle 5 of a scan -> ignored; the frame output is identical to the first scenario.
- X limit=0xFFFF with STEP=2 -> x_reg saturates at 0xFFFF. x_flag then falls, row_end fires, and no wrap to 0 occurs before row_end.
